// File: rtl/hpdcache_victim_evict_ctrl.sv
// Refill victim selection and dirty-victim eviction sequencer for the HPDcache miss path.
// Optional macro HPDCACHE_EVICT_STATS_EN adds saturating eviction/writeback counters.
module hpdcache_victim_evict_ctrl #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SET_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [SET_W-1:0] req_set_i,
  input  logic [WAYS-1:0]  req_dir_valid_i,
  input  logic [WAYS-1:0]  req_dir_dirty_i,
  output logic             sel_victim_o,
  output logic [SET_W-1:0] sel_set_o,
  input  logic [WAYS-1:0]  sel_way_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [SET_W-1:0] wb_set_o,
  output logic [WAYS-1:0]  wb_way_o,
  input  logic             wb_done_i,
  output logic             updt_o,
  output logic [SET_W-1:0] updt_set_o,
  output logic [WAYS-1:0]  updt_way_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WAYS-1:0]  rsp_way_o,
  output logic             err_o
`ifdef HPDCACHE_EVICT_STATS_EN
  ,
  output logic [31:0]      stat_evict_o,
  output logic [31:0]      stat_wback_o
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEL     = 3'd1;
  localparam logic [2:0] ST_WB_REQ  = 3'd2;
  localparam logic [2:0] ST_WB_WAIT = 3'd3;
  localparam logic [2:0] ST_UPDT    = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  localparam logic [WAYS-1:0] WAY_ONE = {{(WAYS-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [WAYS-1:0] v);
    return (v != '0) && ((v & (v - WAY_ONE)) == '0);
  endfunction

  // Lowest set bit of the vector; way 0 when the vector is empty.
  function automatic logic [WAYS-1:0] lowest_way(input logic [WAYS-1:0] v);
    logic [WAYS-1:0] r;
    r = WAY_ONE;
    for (int i = WAYS - 1; i >= 0; i--) begin
      r = v[i] ? (WAY_ONE << i) : r;
    end
    return r;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [SET_W-1:0] set_r;
  logic [WAYS-1:0]  dir_valid_r;
  logic [WAYS-1:0]  dir_dirty_r;
  logic [WAYS-1:0]  way_r;
  logic             err_r;
  logic             req_ready_r;
  logic             sel_victim_r;
  logic             wb_valid_r;
  logic             updt_r;
  logic             rsp_valid_r;

  logic             accept_s;
  logic [WAYS-1:0]  sel_fix_s;
  logic             sel_bad_s;
  logic             victim_wb_s;

  assign accept_s    = req_valid_i & req_ready_r;
  assign sel_fix_s   = lowest_way(sel_way_i);
  assign sel_bad_s   = ~is_onehot(sel_way_i);
  assign victim_wb_s = |(sel_fix_s & dir_valid_r & dir_dirty_r);

  // Next-state decode of the eviction sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_SEL;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SEL: begin
        if (victim_wb_s) state_nxt_s = ST_WB_REQ;
        else             state_nxt_s = ST_UPDT;
      end
      ST_WB_REQ: begin
        if (wb_ready_i) state_nxt_s = ST_WB_WAIT;
        else            state_nxt_s = ST_WB_REQ;
      end
      ST_WB_WAIT: begin
        if (wb_done_i) state_nxt_s = ST_UPDT;
        else           state_nxt_s = ST_WB_WAIT;
      end
      ST_UPDT: state_nxt_s = ST_RSP;
      ST_RSP: begin
        if (rsp_ready_i) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_RSP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus handshake outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b0;
      sel_victim_r <= 1'b0;
      wb_valid_r   <= 1'b0;
      updt_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      req_ready_r  <= (state_nxt_s == ST_IDLE);
      sel_victim_r <= (state_nxt_s == ST_SEL);
      wb_valid_r   <= (state_nxt_s == ST_WB_REQ);
      updt_r       <= (state_nxt_s == ST_UPDT);
      rsp_valid_r  <= (state_nxt_s == ST_RSP);
    end
  end

  // Request fields latched on accept; victim way and sticky error latched in SEL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      set_r       <= '0;
      dir_valid_r <= '0;
      dir_dirty_r <= '0;
      way_r       <= '0;
      err_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        set_r       <= req_set_i;
        dir_valid_r <= req_dir_valid_i;
        dir_dirty_r <= req_dir_dirty_i;
      end
      if (state_r == ST_SEL) begin
        way_r <= sel_fix_s;
        err_r <= err_r | sel_bad_s;
      end
    end
  end

  assign req_ready_o  = req_ready_r;
  assign sel_victim_o = sel_victim_r;
  assign sel_set_o    = set_r;
  assign wb_valid_o   = wb_valid_r;
  assign wb_set_o     = set_r;
  assign wb_way_o     = way_r;
  assign updt_o       = updt_r;
  assign updt_set_o   = set_r;
  assign updt_way_o   = way_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_way_o    = way_r;
  assign err_o        = err_r;

`ifdef HPDCACHE_EVICT_STATS_EN
  logic [31:0] stat_evict_r;
  logic [31:0] stat_wback_r;

  // Saturating counters: policy updates and accepted writeback requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_evict_r <= 32'd0;
      stat_wback_r <= 32'd0;
    end else begin
      if ((state_nxt_s == ST_UPDT) && (stat_evict_r != 32'hFFFF_FFFF)) begin
        stat_evict_r <= stat_evict_r + 32'd1;
      end
      if ((state_r == ST_WB_REQ) && wb_ready_i && (stat_wback_r != 32'hFFFF_FFFF)) begin
        stat_wback_r <= stat_wback_r + 32'd1;
      end
    end
  end

  assign stat_evict_o = stat_evict_r;
  assign stat_wback_o = stat_wback_r;
`endif

endmodule

// File: tb/tb_hpdcache_victim_evict_ctrl.sv
// Self-checking bench for hpdcache_victim_evict_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model of victim choice and timing.
module tb_hpdcache_victim_evict_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [5:0] req_set_i;
  logic [3:0] req_dir_valid_i;
  logic [3:0] req_dir_dirty_i;
  logic       sel_victim_o;
  logic [5:0] sel_set_o;
  logic [3:0] sel_way_i;
  logic       wb_valid_o;
  logic       wb_ready_i;
  logic [5:0] wb_set_o;
  logic [3:0] wb_way_o;
  logic       wb_done_i;
  logic       updt_o;
  logic [5:0] updt_set_o;
  logic [3:0] updt_way_o;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [3:0] rsp_way_o;
  logic       err_o;
`ifdef HPDCACHE_EVICT_STATS_EN
  logic [31:0] stat_evict_o;
  logic [31:0] stat_wback_o;
`endif

  hpdcache_victim_evict_ctrl #(.WAYS(4), .SET_W(6)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
    .req_dir_valid_i(req_dir_valid_i), .req_dir_dirty_i(req_dir_dirty_i),
    .sel_victim_o(sel_victim_o), .sel_set_o(sel_set_o), .sel_way_i(sel_way_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o),
    .wb_way_o(wb_way_o), .wb_done_i(wb_done_i),
    .updt_o(updt_o), .updt_set_o(updt_set_o), .updt_way_o(updt_way_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_way_o(rsp_way_o),
    .err_o(err_o)
`ifdef HPDCACHE_EVICT_STATS_EN
    , .stat_evict_o(stat_evict_o), .stat_wback_o(stat_wback_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic err_exp;
  int   evict_exp;
  int   wback_exp;

  // observations of the last transaction
  bit         o_timeout, o_sel_set_bad, o_wb_unstable, o_rsp_unstable, o_busy_ready;
  int         o_sel_pulses, o_wb_seen, o_updt_cnt, o_updt_lat, o_rsp_lat;
  logic [3:0] o_wb_way, o_updt_way, o_rsp_way;
  logic [5:0] o_updt_set;

  // model: lowest set bit by two's-complement isolation, way 0 for an empty vector
  function automatic logic [3:0] exp_way_f(input logic [3:0] sel);
    logic [3:0] neg;
    neg = ~sel + 4'd1;
    return (sel == 4'd0) ? 4'b0001 : (sel & neg);
  endfunction

  function automatic bit exp_wb_f(input logic [3:0] way, input logic [3:0] v, input logic [3:0] d);
    return (way & v & d) != 4'd0;
  endfunction

  task automatic step;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    step; step;
    rst_i = 1'b0;
    step;
    err_exp = 1'b0; evict_exp = 0; wback_exp = 0;
  endtask

  // Issue one request and play the writeback/response partners with the given delays.
  task automatic do_txn(input logic [5:0] set, input logic [3:0] v, input logic [3:0] d,
                        input logic [3:0] sel, input int dly_wr, input int dly_done,
                        input int dly_rsp, input bit hold_next, input bit noise);
    int  w, k, wbcnt, rspcnt, done_timer;
    bit  done, in_wait;
    o_timeout = 1'b0; o_sel_set_bad = 1'b0; o_wb_unstable = 1'b0; o_rsp_unstable = 1'b0;
    o_busy_ready = 1'b0; o_sel_pulses = 0; o_wb_seen = 0; o_updt_cnt = 0;
    o_updt_lat = -1; o_rsp_lat = -1; o_wb_way = 4'd0; o_updt_way = 4'd0;
    o_rsp_way = 4'd0; o_updt_set = 6'd0;
    w = 0;
    while (req_ready_o !== 1'b1 && w < 20) begin step; w++; end
    if (w == 20) begin o_timeout = 1'b1; return; end
    req_valid_i = 1'b1; req_set_i = set; req_dir_valid_i = v; req_dir_dirty_i = d;
    sel_way_i = sel;
    k = 0; done = 1'b0; in_wait = 1'b0; wbcnt = 0; rspcnt = 0; done_timer = -1;
    while (!done && k < 200) begin
      step; k++;
      wb_ready_i = 1'b0; wb_done_i = 1'b0; rsp_ready_i = 1'b0;
      if (k == 1) begin
        if (hold_next) req_set_i = ~set;
        else           req_valid_i = 1'b0;
      end
      if (req_ready_o) o_busy_ready = 1'b1;
      if (sel_victim_o) begin
        o_sel_pulses++;
        if (sel_set_o !== set) o_sel_set_bad = 1'b1;
      end
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) begin wb_done_i = 1'b1; in_wait = 1'b0; done_timer = -1; end
      end else if (noise && !in_wait) begin
        wb_done_i = 1'($urandom_range(0, 1));
      end
      if (wb_valid_o) begin
        if (o_wb_seen == 0) o_wb_way = wb_way_o;
        else if (wb_way_o !== o_wb_way || wb_set_o !== set) o_wb_unstable = 1'b1;
        o_wb_seen++; wbcnt++;
        if (wbcnt > dly_wr) begin wb_ready_i = 1'b1; done_timer = dly_done; in_wait = 1'b1; end
      end
      if (updt_o) begin
        o_updt_cnt++; o_updt_lat = k; o_updt_way = updt_way_o; o_updt_set = updt_set_o;
      end
      if (rsp_valid_o) begin
        if (rspcnt == 0) begin o_rsp_lat = k; o_rsp_way = rsp_way_o; end
        else if (rsp_way_o !== o_rsp_way) o_rsp_unstable = 1'b1;
        rspcnt++;
        if (rspcnt > dly_rsp) begin rsp_ready_i = 1'b1; done = 1'b1; end
      end
    end
    if (!done) o_timeout = 1'b1;
    step;
    rsp_ready_i = 1'b0; wb_done_i = 1'b0; wb_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    step; step;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready_o); end
    total++;
    if ({sel_victim_o, wb_valid_o, updt_o, rsp_valid_o, err_o, wb_way_o, rsp_way_o, sel_set_o} !== 19'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
                      {sel_victim_o, wb_valid_o, updt_o, rsp_valid_o, err_o, wb_way_o, rsp_way_o, sel_set_o});
    end
    rst_i = 1'b0;
    step;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", req_ready_o); end
    err_exp = 1'b0; evict_exp = 0; wback_exp = 0;
  endtask

  task automatic test_clean;
    do_txn(6'd5, 4'b1111, 4'b0000, 4'b0100, 0, 1, 0, 1'b0, 1'b0);
    total++; if (o_updt_lat !== 2) begin bad++; $display("FAIL clean_updt_lat: got %0d want 2", o_updt_lat); end
    total++; if (o_rsp_lat !== 3) begin bad++; $display("FAIL clean_rsp_lat: got %0d want 3", o_rsp_lat); end
    total++; if (o_rsp_way !== 4'b0100) begin bad++; $display("FAIL clean_rsp_way: got %b want 0100", o_rsp_way); end
    total++; if (o_wb_seen !== 0) begin bad++; $display("FAIL clean_no_wb: got %0d want 0", o_wb_seen); end
    total++; if (o_sel_pulses !== 1 || o_sel_set_bad) begin bad++; $display("FAIL clean_sel_pulse: got %0d/%b want 1/0", o_sel_pulses, o_sel_set_bad); end
    total++; if (o_updt_set !== 6'd5 || o_updt_cnt !== 1) begin bad++; $display("FAIL clean_updt_set: got %0d/%0d want 5/1", o_updt_set, o_updt_cnt); end
    evict_exp++;
  endtask

  task automatic test_dirty;
    do_txn(6'd9, 4'b1111, 4'b0010, 4'b0010, 3, 5, 1, 1'b0, 1'b0);
    total++; if (o_wb_seen !== 4) begin bad++; $display("FAIL dirty_wb_cycles: got %0d want 4", o_wb_seen); end
    total++; if (o_wb_way !== 4'b0010 || o_wb_unstable) begin bad++; $display("FAIL dirty_wb_way: got %b/%b want 0010/0", o_wb_way, o_wb_unstable); end
    total++; if (o_updt_lat !== 11) begin bad++; $display("FAIL dirty_updt_lat: got %0d want 11", o_updt_lat); end
    total++; if (o_rsp_lat !== 12 || o_rsp_way !== 4'b0010) begin bad++; $display("FAIL dirty_rsp: got %0d/%b want 12/0010", o_rsp_lat, o_rsp_way); end
    evict_exp++; wback_exp++;
  endtask

  task automatic test_invalid_dirty;
    do_txn(6'd17, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0, 1'b0, 1'b0);
    total++; if (o_wb_seen !== 0) begin bad++; $display("FAIL invdirty_no_wb: got %0d want 0", o_wb_seen); end
    total++; if (o_rsp_way !== 4'b0001 || o_rsp_lat !== 3) begin bad++; $display("FAIL invdirty_rsp: got %b/%0d want 0001/3", o_rsp_way, o_rsp_lat); end
    evict_exp++;
  endtask

  task automatic test_bad_sel;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL badsel_err_before: got %b want 0", err_o); end
    do_txn(6'd3, 4'b1111, 4'b0000, 4'b0110, 0, 1, 0, 1'b0, 1'b0);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL badsel_err_set: got %b want 1", err_o); end
    total++; if (o_rsp_way !== 4'b0010) begin bad++; $display("FAIL badsel_way_0110: got %b want 0010", o_rsp_way); end
    do_txn(6'd4, 4'b1111, 4'b0000, 4'b0000, 0, 1, 0, 1'b0, 1'b0);
    total++; if (o_rsp_way !== 4'b0001) begin bad++; $display("FAIL badsel_way_zero: got %b want 0001", o_rsp_way); end
    do_txn(6'd4, 4'b1111, 4'b0000, 4'b1000, 0, 1, 0, 1'b0, 1'b0);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL badsel_err_sticky: got %b want 1", err_o); end
    do_reset;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL badsel_err_cleared: got %b want 0", err_o); end
  endtask

  task automatic test_reset_wbwait;
    int w;
    bit stray;
    w = 0;
    while (req_ready_o !== 1'b1 && w < 20) begin step; w++; end
    req_valid_i = 1'b1; req_set_i = 6'd33; req_dir_valid_i = 4'b1111;
    req_dir_dirty_i = 4'b1000; sel_way_i = 4'b1000;
    step; req_valid_i = 1'b0;
    step;
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL rstwb_wb_valid: got %b want 1", wb_valid_o); end
    wb_ready_i = 1'b1;
    step; wb_ready_i = 1'b0;
    rst_i = 1'b1;
    step;
    total++; if ({req_ready_o, wb_valid_o, updt_o, rsp_valid_o} !== 4'd0) begin
      bad++; $display("FAIL rstwb_in_reset: got %b want 0000", {req_ready_o, wb_valid_o, updt_o, rsp_valid_o});
    end
    rst_i = 1'b0;
    step;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rstwb_ready: got %b want 1", req_ready_o); end
    wb_done_i = 1'b1;
    step; wb_done_i = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (updt_o || rsp_valid_o || !req_ready_o) stray = 1'b1;
      step;
    end
    total++; if (stray) begin bad++; $display("FAIL rstwb_late_done: got activity want none"); end
    err_exp = 1'b0; evict_exp = 0; wback_exp = 0;
  endtask

  task automatic test_backpressure;
    do_reset;
    do_txn(6'd10, 4'b1111, 4'b0000, 4'b0001, 0, 1, 4, 1'b1, 1'b0);
    total++; if (o_busy_ready) begin bad++; $display("FAIL bp_ready_while_busy: got 1 want 0"); end
    total++; if (o_rsp_way !== 4'b0001) begin bad++; $display("FAIL bp_first_way: got %b want 0001", o_rsp_way); end
    do_txn(6'd11, 4'b1111, 4'b0000, 4'b0100, 0, 1, 0, 1'b0, 1'b0);
    total++; if (o_rsp_way !== 4'b0100 || o_updt_set !== 6'd11 || o_rsp_lat !== 3) begin
      bad++; $display("FAIL bp_second: got %b/%0d/%0d want 0100/11/3", o_rsp_way, o_updt_set, o_rsp_lat);
    end
    evict_exp += 2;
`ifdef HPDCACHE_EVICT_STATS_EN
    total++; if (stat_evict_o !== 32'd2) begin bad++; $display("FAIL bp_stat_evict: got %0d want 2", stat_evict_o); end
`endif
  endtask

  task automatic test_random;
    logic [3:0] sel, v, d, ew;
    logic [5:0] set;
    int dw, dd, dr, elat;
    bit ewb;
    for (int n = 0; n < 40; n++) begin
      set = 6'($urandom); v = 4'($urandom); d = 4'($urandom);
      sel = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      dw = $urandom_range(0, 3); dd = $urandom_range(1, 4); dr = $urandom_range(0, 3);
      ew = exp_way_f(sel);
      ewb = exp_wb_f(ew, v, d);
      elat = ewb ? (3 + dw + dd) : 2;
      if ($countones(sel) != 1) err_exp = 1'b1;
      do_txn(set, v, d, sel, dw, dd, dr, 1'b0, 1'b1);
      total++; if (o_timeout) begin bad++; $display("FAIL rnd_timeout[%0d]: got timeout want completion", n); end
      total++; if (o_rsp_way !== ew || o_updt_way !== ew || o_rsp_unstable) begin
        bad++; $display("FAIL rnd_way[%0d]: got %b/%b want %b", n, o_rsp_way, o_updt_way, ew);
      end
      total++; if ((o_wb_seen != 0) !== ewb || (ewb && o_wb_way !== ew) || o_wb_unstable) begin
        bad++; $display("FAIL rnd_wb[%0d]: got %0d/%b want %b/%b", n, o_wb_seen, o_wb_way, ewb, ew);
      end
      total++; if (o_updt_lat !== elat || o_rsp_lat !== elat + 1 || o_updt_cnt !== 1) begin
        bad++; $display("FAIL rnd_lat[%0d]: got %0d/%0d want %0d/%0d", n, o_updt_lat, o_rsp_lat, elat, elat + 1);
      end
      total++; if (o_updt_set !== set || err_o !== err_exp) begin
        bad++; $display("FAIL rnd_set_err[%0d]: got %0d/%b want %0d/%b", n, o_updt_set, err_o, set, err_exp);
      end
      evict_exp++;
      if (ewb) wback_exp++;
    end
`ifdef HPDCACHE_EVICT_STATS_EN
    total++; if (stat_evict_o !== 32'(evict_exp) || stat_wback_o !== 32'(wback_exp)) begin
      bad++; $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", stat_evict_o, stat_wback_o, evict_exp, wback_exp);
    end
`endif
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_set_i = 6'd0; req_dir_valid_i = 4'd0;
    req_dir_dirty_i = 4'd0; sel_way_i = 4'd0; wb_ready_i = 1'b0; wb_done_i = 1'b0;
    rsp_ready_i = 1'b0;
    err_exp = 1'b0; evict_exp = 0; wback_exp = 0;
    test_reset;
    test_clean;
    test_dirty;
    test_invalid_dirty;
    test_bad_sel;
    test_reset_wbwait;
    test_backpressure;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
